// File: rtl/scope_tap_pkg.sv
// Shared definitions for the scope tap capture block: FSM encoding and timestamp width.
// Timestamp support is selected in scope_tap_capture by SCOPE_TAP_TIMESTAMP_EN.
package scope_tap_pkg;

    localparam int TS_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_TRIG  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_ARMED     = ST_ARMED,
        S_TRIGGERED = ST_TRIG,
        S_DONE      = ST_DONE
    } state_e;

endpackage

// File: rtl/scope_tap_trig.sv
// Trigger evaluation: selects one tapped channel, applies the masked compare and
// qualifies it with an edge history that only advances on qualified samples.
module scope_tap_trig
    import scope_tap_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 32,
    parameter int CSW    = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH*CH_W-1:0]   tap_data,
    input  logic [CSW-1:0]           trig_ch,
    input  logic [CH_W-1:0]          trig_mask,
    input  logic [CH_W-1:0]          trig_val,
    input  logic                     trig_edge,
    input  logic                     hist_clr,
    input  logic                     hist_upd,
    output logic                     hit
);

    logic [CH_W-1:0] ch_sel;
    logic            ch_ok;
    logic            match;
    logic            prev_match_q, prev_match_d;
    logic            hist_vld_q, hist_vld_d;

    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (trig_ch == CSW'(k)) begin
                ch_sel = tap_data[k*CH_W +: CH_W];
            end
        end
    end

    assign ch_ok = (32'(trig_ch) < 32'(NUM_CH));
    assign match = ch_ok && ((ch_sel & trig_mask) == (trig_val & trig_mask));

    // Without a previous qualified sample there is no edge to detect.
    assign hit = match && (!trig_edge || (hist_vld_q && !prev_match_q));

    always_comb begin
        prev_match_d = prev_match_q;
        hist_vld_d   = hist_vld_q;
        if (hist_clr) begin
            prev_match_d = 1'b0;
            hist_vld_d   = 1'b0;
        end else if (hist_upd) begin
            prev_match_d = match;
            hist_vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_match_q <= 1'b0;
            hist_vld_q   <= 1'b0;
        end else begin
            prev_match_q <= prev_match_d;
            hist_vld_q   <= hist_vld_d;
        end
    end

endmodule

// File: rtl/scope_tap_capture.sv
// Triggered capture of tapped channels into a circular flop buffer with post-trigger
// count and indexed readout. Define SCOPE_TAP_TIMESTAMP_EN to store a 16-bit timestamp per entry.
module scope_tap_capture
    import scope_tap_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CH_W   = 32,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CSW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef SCOPE_TAP_TIMESTAMP_EN
    localparam int RD_W   = NUM_CH*CH_W + TS_W
`else
    localparam int RD_W   = NUM_CH*CH_W
`endif
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_CH*CH_W-1:0] tap_data,
    input  logic                   tap_en,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [CSW-1:0]         trig_ch,
    input  logic [CH_W-1:0]        trig_mask,
    input  logic [CH_W-1:0]        trig_val,
    input  logic                   trig_edge,
    input  logic [AW-1:0]          post_cnt,
    output logic [1:0]             state,
    output logic                   done,
    output logic [AW:0]            fill,
    output logic [AW-1:0]          trig_idx,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic                   rd_valid,
    output logic [RD_W-1:0]        rd_data
);

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   post_q, post_d;
    logic [AW-1:0]   trig_idx_q, trig_idx_d;
    logic [AW:0]     fill_q, fill_d;
    logic [AW:0]     fill_inc;
    logic            rd_valid_q;
    logic [RD_W-1:0] rd_data_q, rd_data_d;
    logic [AW-1:0]   rd_phys;
    logic            wr_en;
    logic            hist_clr;
    logic            hist_upd;
    logic            hit;
    logic [RD_W-1:0] wr_entry;
    logic [RD_W-1:0] mem_q [DEPTH];

`ifdef SCOPE_TAP_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clock) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    assign wr_entry = {ts_q, tap_data};
`else
    assign wr_entry = tap_data;
`endif

    scope_tap_trig #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .CSW    (CSW)
    ) u_trig (
        .clock     (clock),
        .reset_n   (reset_n),
        .tap_data  (tap_data),
        .trig_ch   (trig_ch),
        .trig_mask (trig_mask),
        .trig_val  (trig_val),
        .trig_edge (trig_edge),
        .hist_clr  (hist_clr),
        .hist_upd  (hist_upd),
        .hit       (hit)
    );

    assign fill_inc = (fill_q == (AW+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;
    assign hist_upd = tap_en && ((state_q == ST_ARMED) || (state_q == ST_TRIG));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        post_d     = post_q;
        fill_d     = fill_q;
        trig_idx_d = trig_idx_q;
        wr_en      = 1'b0;
        hist_clr   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            fill_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d    = ST_ARMED;
                        wr_ptr_d   = '0;
                        fill_d     = '0;
                        trig_idx_d = '0;
                        cnt_d      = '0;
                        hist_clr   = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (tap_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        fill_d   = fill_inc;
                        if (hit) begin
                            state_d = ST_TRIG;
                            cnt_d   = post_cnt;
                            post_d  = post_cnt;
                        end
                    end
                end
                default: begin
                    // Counter already exhausted: close the capture without writing.
                    if (cnt_q == '0) begin
                        state_d    = ST_DONE;
                        trig_idx_d = AW'(fill_q - (AW+1)'(1) - {1'b0, post_q});
                    end else if (tap_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        fill_d   = fill_inc;
                        cnt_d    = cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign rd_phys = ((fill_q == (AW+1)'(DEPTH)) ? wr_ptr_q : '0) + rd_addr;

    always_comb begin
        rd_data_d = '0;
        if (rd_en && (state_q == ST_DONE) && ({1'b0, rd_addr} < fill_q)) begin
            rd_data_d = mem_q[rd_phys];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            post_q     <= '0;
            fill_q     <= '0;
            trig_idx_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            post_q     <= post_d;
            fill_q     <= fill_d;
            trig_idx_q <= trig_idx_d;
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && reset_n) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign state    = state_q;
    assign done     = (state_q == ST_DONE);
    assign fill     = fill_q;
    assign trig_idx = trig_idx_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_scope_tap_capture.sv
// Self-checking bench for scope_tap_capture: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_scope_tap_capture;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int CSW    = 2;
`ifdef SCOPE_TAP_TIMESTAMP_EN
    localparam int RD_W   = NUM_CH*CH_W + 16;
`else
    localparam int RD_W   = NUM_CH*CH_W;
`endif

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [NUM_CH*CH_W-1:0] tap_data;
    logic                   tap_en, arm, abort, trig_edge, rd_en;
    logic [CSW-1:0]         trig_ch;
    logic [CH_W-1:0]        trig_mask, trig_val;
    logic [AW-1:0]          post_cnt, trig_idx, rd_addr;
    logic [1:0]             state;
    logic                   done, rd_valid;
    logic [AW:0]            fill;
    logic [RD_W-1:0]        rd_data;

    always #5 clock = ~clock;

    scope_tap_capture #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .tap_data(tap_data), .tap_en(tap_en),
        .arm(arm), .abort(abort), .trig_ch(trig_ch), .trig_mask(trig_mask),
        .trig_val(trig_val), .trig_edge(trig_edge), .post_cnt(post_cnt),
        .state(state), .done(done), .fill(fill), .trig_idx(trig_idx),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [RD_W-1:0] act, input logic [RD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: the capture is the list of samples written since arm,
    // trimmed to the newest DEPTH entries.
    int              m_st = 0;
    logic [RD_W-1:0] m_q[$];
    int              m_nq = 0;
    bit              m_prev = 0;
    int              m_after = 0;
    int              m_post = 0;
    int              m_tidx = 0;
    bit              m_rdv = 0;
    logic [RD_W-1:0] m_rdd = '0;
    logic [15:0]     m_ts = '0;

    task automatic m_push(input logic [RD_W-1:0] e);
        if (m_q.size() == DEPTH) void'(m_q.pop_front());
        m_q.push_back(e);
    endtask

    always @(posedge clock) begin
        logic [RD_W-1:0] entry;
        logic [CH_W-1:0] ch;
        bit              m, hit;
        if (!reset_n) begin
            m_st = 0; m_q.delete(); m_nq = 0; m_prev = 0; m_after = 0; m_post = 0;
            m_tidx = 0; m_rdv = 0; m_rdd = '0; m_ts = '0;
        end else begin
`ifdef SCOPE_TAP_TIMESTAMP_EN
            entry = {m_ts, tap_data};
`else
            entry = tap_data;
`endif
            m_rdv = rd_en;
            m_rdd = (rd_en && m_st == 3 && rd_addr < m_q.size()) ? m_q[rd_addr] : '0;
            ch = '0;
            if (trig_ch < NUM_CH) ch = tap_data[trig_ch*CH_W +: CH_W];
            m = (trig_ch < NUM_CH) && ((ch & trig_mask) == (trig_val & trig_mask));
            if (abort) begin
                m_st = 0;
                m_q.delete();
            end else begin
                case (m_st)
                    0, 3: if (arm) begin
                        m_st = 1; m_q.delete(); m_nq = 0; m_prev = 0; m_tidx = 0;
                    end
                    1: if (tap_en) begin
                        m_push(entry);
                        hit = m && (!trig_edge || (m_nq > 0 && !m_prev));
                        m_prev = m;
                        m_nq++;
                        if (hit) begin
                            m_st = 2; m_after = 0; m_post = int'(post_cnt);
                        end
                    end
                    default: begin
                        if (m_after == m_post) begin
                            m_st = 3;
                            m_tidx = m_q.size() - 1 - m_post;
                        end else if (tap_en) begin
                            m_push(entry);
                            m_after++;
                        end
                    end
                endcase
            end
            m_ts = m_ts + 16'd1;
        end
    end

    always @(negedge clock) begin
        chk("state", state, m_st);
        chk("done", done, (m_st == 3));
        chk("fill", fill, m_q.size());
        chk("trig_idx", trig_idx, m_tidx);
        chk("rd_valid", rd_valid, m_rdv);
        chk("rd_data", rd_data, m_rdd);
    end

    task automatic rand_other_ch();
        for (int k = 1; k < NUM_CH; k++) tap_data[k*CH_W +: CH_W] = CH_W'($urandom);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tap_en = 1'b0;
        @(negedge clock);
        arm = 1'b0;
    endtask

    task automatic count_until_done(input int start);
        int v;
        bit seen;
        v = start; seen = 0;
        tap_en = 1'b1;
        for (int n = 0; n < 200 && !seen; n++) begin
            tap_data[CH_W-1:0] = CH_W'(v);
            rand_other_ch();
            v++;
            @(negedge clock);
            if (done) seen = 1;
        end
        tap_en = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_done actual=timeout required=done");
        end
    endtask

    task automatic read_ch(input int a, input int k, input int exp, input string nm);
        rd_en = 1'b1; rd_addr = AW'(a);
        @(negedge clock);
        rd_en = 1'b0;
        chk({nm, "_valid"}, rd_valid, 1);
        chk(nm, rd_data[k*CH_W +: CH_W], exp);
    endtask

    task automatic basic_capture();
        trig_ch = 0; trig_edge = 0; trig_mask = '1; trig_val = 5; post_cnt = 3;
        pulse_arm();
        count_until_done(0);
        chk("basic_state", state, 3);
        chk("basic_fill", fill, 9);
        chk("basic_trig_idx", trig_idx, 5);
        for (int a = 0; a < 9; a++) read_ch(a, 0, a, $sformatf("basic_rd%0d", a));
    endtask

    initial begin
        reset_n = 0; tap_data = '0; tap_en = 0; arm = 0; abort = 0; trig_ch = 0;
        trig_mask = '1; trig_val = '0; trig_edge = 0; post_cnt = '0; rd_en = 0; rd_addr = '0;
        repeat (3) @(negedge clock);
        chk("rst_state", state, 0);
        chk("rst_fill", fill, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        reset_n = 1;
        @(negedge clock);

        basic_capture();

        // Wrapped buffer: trigger at 40 with 7 post samples.
        trig_val = 40; post_cnt = 7;
        pulse_arm();
        count_until_done(0);
        chk("wrap_fill", fill, 16);
        chk("wrap_trig_idx", trig_idx, 8);
        read_ch(0, 0, 32, "wrap_rd0");
        read_ch(15, 0, 47, "wrap_rd15");
        read_ch(8, 0, 40, "wrap_rd8");

        // Edge trigger on ch1: held 5 from arm, then 0, then 5.
        begin
            int seq[6] = '{5, 5, 5, 0, 0, 5};
            bit seen;
            trig_ch = 1; trig_edge = 1; trig_mask = '1; trig_val = 5; post_cnt = 2;
            pulse_arm();
            tap_en = 1; seen = 0;
            for (int n = 0; n < 50 && !seen; n++) begin
                tap_data[CH_W-1:0] = CH_W'(n);
                tap_data[CH_W +: CH_W] = (n < 6) ? CH_W'(seq[n]) : CH_W'(9);
                @(negedge clock);
                if (done) seen = 1;
            end
            tap_en = 0;
            chk("edge_done", done, 1);
            chk("edge_fill", fill, 8);
            chk("edge_trig_idx", trig_idx, 5);
            read_ch(5, 0, 5, "edge_rd5_ch0");
            read_ch(5, 1, 5, "edge_rd5_ch1");
            read_ch(0, 1, 5, "edge_rd0_ch1");
        end

        // Abort coincident with the trigger sample.
        trig_ch = 0; trig_edge = 0; trig_val = 5; post_cnt = 3;
        pulse_arm();
        tap_en = 1;
        for (int v = 0; v <= 5; v++) begin
            tap_data[CH_W-1:0] = CH_W'(v);
            abort = (v == 5);
            @(negedge clock);
        end
        abort = 0; tap_en = 0;
        chk("abort_state", state, 0);
        chk("abort_fill", fill, 0);
        rd_en = 1; rd_addr = '0;
        @(negedge clock);
        rd_en = 0;
        chk("abort_rd_valid", rd_valid, 1);
        chk("abort_rd_data", rd_data, 0);

        // Reset pulse while TRIGGERED, then a normal capture.
        trig_val = 5; post_cnt = 7;
        pulse_arm();
        tap_en = 1;
        for (int v = 0; v <= 7; v++) begin
            tap_data[CH_W-1:0] = CH_W'(v);
            @(negedge clock);
        end
        tap_en = 0;
        chk("midrst_pre_state", state, 2);
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        chk("midrst_state", state, 0);
        chk("midrst_done", done, 0);
        chk("midrst_fill", fill, 0);
        @(negedge clock);
        basic_capture();

`ifdef SCOPE_TAP_TIMESTAMP_EN
        begin
            logic [15:0] t0, t1;
            bit seen;
            trig_ch = 0; trig_edge = 0; trig_mask = '0; post_cnt = 4;
            pulse_arm();
            seen = 0;
            for (int n = 0; n < 60 && !seen; n++) begin
                tap_en = (n % 2 == 0);
                tap_data[CH_W-1:0] = CH_W'(n);
                @(negedge clock);
                if (done) seen = 1;
            end
            tap_en = 0;
            chk("ts_fill", fill, 5);
            rd_en = 1; rd_addr = 0; @(negedge clock);
            t0 = rd_data[RD_W-1 -: 16];
            rd_addr = 1; @(negedge clock);
            t1 = rd_data[RD_W-1 -: 16];
            rd_en = 0;
            chk("ts_delta", t1 - t0, 2);
        end
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                trig_ch   = CSW'($urandom_range(0, NUM_CH-1));
                trig_edge = 1'($urandom_range(0, 1));
                trig_mask = CH_W'($urandom_range(0, 3));
                trig_val  = CH_W'($urandom);
                post_cnt  = AW'($urandom);
            end
            for (int k = 0; k < NUM_CH; k++) tap_data[k*CH_W +: CH_W] = CH_W'($urandom);
            tap_en  = ($urandom_range(0, 3) != 0);
            arm     = ($urandom_range(0, 15) == 0);
            abort   = ($urandom_range(0, 99) == 0);
            reset_n = ($urandom_range(0, 999) != 0);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom);
            @(negedge clock);
        end
        tap_en = 0; arm = 0; abort = 0; rd_en = 0; reset_n = 1;
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scope_tap_capture.md
SCOPE_TAP_CAPTURE -- requirements
Module: scope_tap_capture

Interface
REQ-001 Parameter NUM_CH, default 4: number of tapped channels, range 1..8.
REQ-002 Parameter CH_W, default 32: width of each channel, range 1..64.
REQ-003 Parameter DEPTH, default 16: capture buffer entries; power of two, at least 2.
REQ-004 Port clock  input  1: single clock; all state on its rising edge.
REQ-005 Port reset_n  input  1: reset, synchronous, active-low.
REQ-006 Port tap_data  input  NUM_CH*CH_W: tapped signals; channel k occupies bits [k*CH_W +: CH_W].
REQ-007 Port tap_en  input  1: sample qualifier; only qualified cycles are written or evaluated for trigger.
REQ-008 Port arm  input  1: single-cycle pulse that starts a capture.
REQ-009 Port abort  input  1: single-cycle pulse that cancels a capture.
REQ-010 Port trig_ch  input  clog2(NUM_CH), min 1: trigger channel select.
REQ-011 Ports trig_mask, trig_val  input  CH_W each: the trigger matches when (ch & trig_mask) == (trig_val & trig_mask).
REQ-012 Port trig_edge  input  1: 0 = level match; 1 = match now and no match on the previous qualified sample.
REQ-013 Port post_cnt  input  clog2(DEPTH): number of qualified samples captured after the trigger sample.
REQ-014 Port state  output  2: current FSM state.
REQ-015 Port done  output  1: high while in DONE.
REQ-016 Port fill  output  clog2(DEPTH)+1: number of valid entries, saturating at DEPTH.
REQ-017 Port trig_idx  output  clog2(DEPTH): readout index of the trigger sample.
REQ-018 Ports rd_en  input  1 and rd_addr  input  clog2(DEPTH): readout request; index 0 is the oldest entry.
REQ-019 Ports rd_valid  output  1 and rd_data  output  RD_W: readout response; RD_W = NUM_CH*CH_W, or NUM_CH*CH_W+16 when timestamps are enabled.

Function
REQ-020 FSM states: IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
REQ-021 From IDLE or DONE, arm moves to ARMED and clears wr_ptr, fill, trig_idx and the edge-history flag; arm in ARMED or TRIGGERED is ignored.
REQ-022 In ARMED and TRIGGERED, each qualified cycle writes tap_data at wr_ptr, increments wr_ptr modulo DEPTH (wrapping DEPTH-1 to 0) and increments fill with saturation.
REQ-023 In ARMED, a qualified cycle meeting the trigger condition writes that sample, moves to TRIGGERED and loads a down-counter with post_cnt.
REQ-024 In TRIGGERED, each qualified write decrements the counter; the cycle after the counter reaches 0 with no further write pending, the state moves to DONE.
REQ-025 With post_cnt=0, the state moves to DONE the cycle after the trigger sample is written.
REQ-026 The edge-history flag updates only on qualified cycles, so the first qualified sample after arm can never satisfy an edge trigger.
REQ-027 A trig_ch value of NUM_CH or higher never triggers.
REQ-028 In DONE the buffer is frozen; tap_en is ignored.
REQ-029 Physical read address = (fill==DEPTH ? wr_ptr : 0) + rd_addr, modulo DEPTH.
REQ-030 trig_idx = fill at DONE minus 1 minus post_cnt, i.e. the logical index of the trigger sample.
REQ-031 rd_valid is asserted exactly 1 cycle after rd_en in any state.
REQ-032 rd_data is the stored entry only when in DONE and rd_addr < fill; otherwise rd_data is 0.
REQ-033 abort has priority over arm and over a trigger on the same cycle, and moves the FSM to IDLE; buffer contents are retained but fill is cleared.

Reset
REQ-034 While reset_n=0 at a clock edge: state=IDLE, done=0, fill=0, trig_idx=0, rd_valid=0, rd_data=0, wr_ptr=0, counter=0, edge history=0.
REQ-035 Buffer storage is not reset; reset mid-capture discards the capture.

Configuration
REQ-036 Macro SCOPE_TAP_TIMESTAMP_EN, when defined, adds a 16-bit free-running counter that is reset to 0, increments every clock and wraps.
REQ-037 With the macro defined, each written entry stores the counter value in rd_data MSBs [RD_W-1 -: 16].
REQ-038 Without the macro, there is no counter and RD_W = NUM_CH*CH_W.

Structure
REQ-039 Package scope_tap_pkg holds the state enum typedef and the constant TS_W=16.
REQ-040 Sub-module scope_tap_trig holds the channel mux, masked compare and edge-history flop, and outputs a 1-bit hit.
REQ-041 The buffer is a flop array inside scope_tap_capture.

Verification
REQ-042 Defaults; arm; tap_en=1; ch0 = 0,1,2,...; trig_val=5, mask=FFFFFFFF, post_cnt=3 -> DONE after value 8 is written; fill=9; trig_idx=5; rd_addr 0..8 return 0..8.
REQ-043 Same setup with trigger at value 40 and post_cnt=7 -> fill=16; rd_addr 0 returns 32, rd_addr 15 returns 47; trig_idx=8.
REQ-044 trig_edge=1, ch1 held at 5 from arm, then 0, then 5 -> triggers only on the second 5.
REQ-045 abort and trigger on the same cycle -> state=IDLE, fill=0; rd_en returns rd_valid=1, rd_data=0.
REQ-046 reset_n=0 for one cycle during TRIGGERED -> next cycle state=IDLE, done=0, fill=0; a later arm captures normally.
REQ-047 With SCOPE_TAP_TIMESTAMP_EN defined and tap_en on alternate cycles -> consecutive entries' timestamps differ by 2.
